bsg_mcl_axil_rx_reader: RTL and testbench
=========================================

BSG_MCL_AXIL_RX_READER -- requirements
Module: bsg_mcl_axil_rx_reader

Interface
REQ-001 SHALL have parameter axil_data_width_p, default 32, AXI-Lite data width and width of the request word consumed from the RX FIFO.
REQ-002 SHALL have parameter axil_addr_width_p, default 32, AXI-Lite address width.
REQ-003 SHALL have parameter credits_width_p, default 5, width of the RX FIFO occupancy count input; SHALL be at most axil_data_width_p.
REQ-004 SHALL have port clk_i, input, 1, the only clock; one clock domain, all state updates on its rising edge.
REQ-005 SHALL have port reset_n_i, input, 1; reset is synchronous and active-low.
REQ-006 SHALL have port s_axil_araddr_i, input, axil_addr_width_p, read address.
REQ-007 SHALL have port s_axil_arvalid_i, input, 1, read address valid.
REQ-008 SHALL have port s_axil_arready_o, output, 1, read address ready.
REQ-009 SHALL have port s_axil_rdata_o, output, axil_data_width_p, read data.
REQ-010 SHALL have port s_axil_rresp_o, output, 2, read response.
REQ-011 SHALL have port s_axil_rvalid_o, output, 1, read data valid.
REQ-012 SHALL have port s_axil_rready_i, input, 1, read data ready.
REQ-013 SHALL have port rx_req_i, input, axil_data_width_p, head word of the RX request buffer.
REQ-014 SHALL have port rx_req_v_i, input, 1, head word valid.
REQ-015 SHALL have port rx_req_yumi_o, output, 1, dequeue of the head word.
REQ-016 SHALL have port rx_req_count_i, input, credits_width_p, current RX buffer occupancy in words.

Function
REQ-017 SHALL decode araddr[7:0] as follows: 0x00 is RX_DATA, 0x04 is RX_COUNT, 0x08 is RX_POPPED; address bits above [7:0] SHALL be ignored.
REQ-018 SHALL implement a two-state FSM, IDLE and RESP, with IDLE as the reset state.
REQ-019 In IDLE, arready SHALL be 1 and rvalid SHALL be 0; an AR handshake (arvalid & arready) SHALL move the FSM to RESP on the next edge.
REQ-020 In RESP, arready SHALL be 0 and rvalid SHALL be 1; rvalid & rready SHALL move the FSM to IDLE; otherwise rdata and rresp SHALL hold stable.
REQ-021 Only one outstanding read SHALL be allowed; AR SHALL NOT be accepted in the same cycle that R completes; maximum throughput SHALL be one read per 2 cycles.
REQ-022 Latency: AR handshake at cycle N SHALL give rvalid=1 at cycle N+1.
REQ-023 RX_DATA read with rx_req_v_i=1 at the AR handshake: rx_req_yumi_o SHALL be 1 in that cycle only; rx_req_i SHALL be latched as rdata; rresp SHALL be OKAY (2'b00).
REQ-024 RX_DATA read with rx_req_v_i=0: there SHALL be no yumi; rdata SHALL be 0 and rresp SHALL be SLVERR (2'b10).
REQ-025 rx_req_yumi_o SHALL never be 1 outside an RX_DATA AR handshake with rx_req_v_i=1; it SHALL be combinational from the handshake and rx_req_v_i.
REQ-026 RX_COUNT read: rdata SHALL be rx_req_count_i sampled at the AR handshake, zero-extended; rresp SHALL be OKAY.
REQ-027 RX_POPPED: a 32-bit counter, truncated or zero-extended to axil_data_width_p on read, SHALL increment by 1 on every yumi and wrap from 0xFFFFFFFF to 0; a read SHALL return its value before any same-cycle increment; rresp SHALL be OKAY.
REQ-028 Any other offset SHALL return rdata=0 and rresp=DECERR (2'b11), with no side effects.

Reset
REQ-029 While reset_n_i=0 at a rising edge: FSM SHALL go to IDLE; rdata, rresp and the RX_POPPED counter SHALL be set to 0.
REQ-030 During reset, s_axil_rvalid_o SHALL be 0, rx_req_yumi_o SHALL be 0 and s_axil_arready_o SHALL be 0.
REQ-031 After reset_n_i returns to 1, arready SHALL be 1 in the first cycle.
REQ-032 Reset asserted in RESP SHALL drop the pending response; no yumi SHALL be reissued after reset.

Verification
REQ-033 Bench SHALL cover: rx_req_v_i=1, rx_req_i=0xDEADBEEF, read 0x00 with rready=1 -> one-cycle yumi, next cycle rvalid with rdata=0xDEADBEEF and rresp=00, RX_POPPED becomes 1.
REQ-034 Bench SHALL cover: rx_req_v_i=0, read 0x00 -> no yumi, rdata=0, rresp=10.
REQ-035 Bench SHALL cover: rx_req_count_i=7, read 0x04 with rready held 0 for 3 cycles while count changes to 2 -> rvalid held with rdata=7 throughout, arready=0 throughout.
REQ-036 Bench SHALL cover: read 0x10 -> rdata=0, rresp=11, no yumi, counter unchanged.
REQ-037 Bench SHALL cover: arvalid held 1 continuously with rready=1 -> accepts alternate cycles, exactly one yumi per accepted RX_DATA read.
REQ-038 Bench SHALL cover: reset_n_i=0 applied in RESP -> rvalid=0 and counter=0 on the next edge, arready=1 after release.

Source files
------------

// File: rtl/bsg_mcl_axil_rx_reader.sv
// rtl/bsg_mcl_axil_rx_reader.sv - AXI-Lite read-only window onto an RX request FIFO
// Serves RX_DATA (pops head word), RX_COUNT (occupancy) and RX_POPPED (pop counter).
module bsg_mcl_axil_rx_reader #(
  parameter int axil_data_width_p = 32,
  parameter int axil_addr_width_p = 32,
  parameter int credits_width_p   = 5
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,

  input  logic [axil_addr_width_p-1:0] s_axil_araddr_i,
  input  logic                         s_axil_arvalid_i,
  output logic                         s_axil_arready_o,
  output logic [axil_data_width_p-1:0] s_axil_rdata_o,
  output logic [1:0]                   s_axil_rresp_o,
  output logic                         s_axil_rvalid_o,
  input  logic                         s_axil_rready_i,

  input  logic [axil_data_width_p-1:0] rx_req_i,
  input  logic                         rx_req_v_i,
  output logic                         rx_req_yumi_o,
  input  logic [credits_width_p-1:0]   rx_req_count_i
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  localparam logic [7:0] OFFSET_RX_DATA   = 8'h00;
  localparam logic [7:0] OFFSET_RX_COUNT  = 8'h04;
  localparam logic [7:0] OFFSET_RX_POPPED = 8'h08;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Pop counter is always 32 bits; widen first so both truncation and zero-extension work.
  localparam int popped_wide_w = (axil_data_width_p > 32) ? axil_data_width_p : 32;

  state_e                         state_q, state_d;
  logic [axil_data_width_p-1:0]   rdata_q, rdata_d;
  logic [1:0]                     rresp_q, rresp_d;
  logic [31:0]                    popped_q, popped_d;

  logic [7:0]                     ar_offset;
  logic [popped_wide_w-1:0]       popped_wide;
  logic [axil_data_width_p-1:0]   popped_rd;
  logic                           arready;
  logic                           rvalid;
  logic                           yumi;
  logic                           unused_addr_hi;

  assign ar_offset      = s_axil_araddr_i[7:0];
  assign unused_addr_hi = ^s_axil_araddr_i[axil_addr_width_p-1:8];
  assign popped_wide    = popped_wide_w'(popped_q);
  assign popped_rd      = popped_wide[axil_data_width_p-1:0];

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    popped_d = popped_q;
    arready  = 1'b0;
    rvalid   = 1'b0;
    yumi     = 1'b0;

    unique case (state_q)
      IDLE: begin
        arready = reset_n_i;
        if (reset_n_i && s_axil_arvalid_i) begin
          state_d = RESP;
          unique case (ar_offset)
            OFFSET_RX_DATA: begin
              if (rx_req_v_i) begin
                yumi    = 1'b1;
                rdata_d = rx_req_i;
                rresp_d = RESP_OKAY;
              end else begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
              end
            end
            OFFSET_RX_COUNT: begin
              rdata_d = axil_data_width_p'(rx_req_count_i);
              rresp_d = RESP_OKAY;
            end
            OFFSET_RX_POPPED: begin
              rdata_d = popped_rd;
              rresp_d = RESP_OKAY;
            end
            default: begin
              rdata_d = '0;
              rresp_d = RESP_DECERR;
            end
          endcase
        end
      end
      RESP: begin
        rvalid = reset_n_i;
        if (s_axil_rready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The read above captured the pre-increment value.
    if (yumi) begin
      popped_d = popped_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
      popped_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      popped_q <= popped_d;
    end
  end

  assign s_axil_arready_o = arready;
  assign s_axil_rvalid_o  = rvalid;
  assign s_axil_rdata_o   = rdata_q;
  assign s_axil_rresp_o   = rresp_q;
  assign rx_req_yumi_o    = yumi;

endmodule

// File: tb/tb_bsg_mcl_axil_rx_reader.sv
// tb/tb_bsg_mcl_axil_rx_reader.sv - directed vector table plus randomized model check
module tb_bsg_mcl_axil_rx_reader;

  logic        clk;
  logic        reset_n;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] rx_req;
  logic        rx_req_v;
  logic        rx_req_yumi;
  logic [4:0]  rx_req_count;

  int checks_total;
  int checks_passed;
  int cyc;

  bsg_mcl_axil_rx_reader #(
    .axil_data_width_p(32),
    .axil_addr_width_p(32),
    .credits_width_p  (5)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .s_axil_araddr_i (araddr),
    .s_axil_arvalid_i(arvalid),
    .s_axil_arready_o(arready),
    .s_axil_rdata_o  (rdata),
    .s_axil_rresp_o  (rresp),
    .s_axil_rvalid_o (rvalid),
    .s_axil_rready_i (rready),
    .rx_req_i        (rx_req),
    .rx_req_v_i      (rx_req_v),
    .rx_req_yumi_o   (rx_req_yumi),
    .rx_req_count_i  (rx_req_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [31:0] addr;
    logic        av;
    logic        rr;
    logic        rv;
    logic [31:0] rq;
    logic [4:0]  cnt;
    logic        e_ar;
    logic        e_rv;
    logic        e_y;
    logic        chk_d;
    logic [31:0] e_rd;
    logic [1:0]  e_rs;
  } vec_t;

  vec_t tbl[$];

  // Reference model: one pending response slot and a popped tally.
  bit          m_pend;
  logic [31:0] m_rd;
  logic [1:0]  m_rs;
  logic [31:0] m_pop;
  bit          m_ar, m_rv, m_y;

  function automatic vec_t mk(logic rst_n, logic [31:0] addr, logic av, logic rr, logic rv,
                              logic [31:0] rq, logic [4:0] cnt, logic e_ar, logic e_rv,
                              logic e_y, logic chk_d, logic [31:0] e_rd, logic [1:0] e_rs);
    vec_t v;
    v.rst_n = rst_n; v.addr = addr; v.av = av; v.rr = rr; v.rv = rv; v.rq = rq; v.cnt = cnt;
    v.e_ar = e_ar; v.e_rv = e_rv; v.e_y = e_y; v.chk_d = chk_d; v.e_rd = e_rd; v.e_rs = e_rs;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  task automatic drive(input logic rst_n, input logic [31:0] addr, input logic av,
                       input logic rr, input logic rv, input logic [31:0] rq, input logic [4:0] cnt);
    @(negedge clk);
    reset_n = rst_n; araddr = addr; arvalid = av; rready = rr;
    rx_req_v = rv; rx_req = rq; rx_req_count = cnt;
    #1;
    cyc++;
  endtask

  task automatic model_eval();
    m_ar = reset_n && !m_pend;
    m_rv = reset_n && m_pend;
    m_y  = m_ar && arvalid && (araddr[7:0] == 8'h00) && rx_req_v;
  endtask

  // Applies the clock edge that follows the current inputs.
  task automatic model_adv();
    if (!reset_n) begin
      m_pend = 0; m_pop = 0; m_rd = 0; m_rs = 0;
    end else if (m_pend) begin
      if (rready) m_pend = 0;
    end else if (arvalid) begin
      m_pend = 1;
      case (araddr[7:0])
        8'h00: if (rx_req_v) begin m_rd = rx_req; m_rs = 2'b00; end
               else begin m_rd = 0; m_rs = 2'b10; end
        8'h04: begin m_rd = {27'd0, rx_req_count}; m_rs = 2'b00; end
        8'h08: begin m_rd = m_pop; m_rs = 2'b00; end
        default: begin m_rd = 0; m_rs = 2'b11; end
      endcase
      if (m_y) m_pop = m_pop + 1;
    end
  endtask

  initial begin
    checks_total = 0; checks_passed = 0; cyc = 0;
    m_pend = 0; m_rd = 0; m_rs = 0; m_pop = 0;
    reset_n = 0; araddr = 0; arvalid = 0; rready = 0;
    rx_req = 0; rx_req_v = 0; rx_req_count = 0;

    //              rst addr          av rr rv rq            cnt  ar rv y  cd rd            rs
    tbl.push_back(mk(0, 32'h0,        0, 0, 0, 32'h0,        0,   0, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk(0, 32'h0,        0, 0, 0, 32'h0,        0,   0, 0, 0, 1, 32'h0,        0));
    tbl.push_back(mk(1, 32'h0,        0, 0, 0, 32'h0,        0,   1, 0, 0, 1, 32'h0,        0));
    // RX_DATA with valid head word
    tbl.push_back(mk(1, 32'h0,        1, 1, 1, 32'hDEADBEEF, 0,   1, 0, 1, 0, 32'h0,        0));
    tbl.push_back(mk(1, 32'h0,        0, 1, 0, 32'h0,        0,   0, 1, 0, 1, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 32'h8,        1, 1, 0, 32'h0,        0,   1, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 32'h0,        0, 1, 0, 32'h0,        0,   0, 1, 0, 1, 32'h1,        0));
    // RX_DATA with empty FIFO
    tbl.push_back(mk(1, 32'h0,        1, 1, 0, 32'h12345678, 0,   1, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 32'h0,        0, 1, 0, 32'h0,        0,   0, 1, 0, 1, 32'h0,        2));
    // RX_COUNT with back-pressure while count changes and arvalid stays high
    tbl.push_back(mk(1, 32'h4,        1, 0, 1, 32'h0,        7,   1, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 32'h0,        1, 0, 1, 32'h5,        2,   0, 1, 0, 1, 32'h7,        0));
    tbl.push_back(mk(1, 32'h0,        1, 0, 1, 32'h5,        2,   0, 1, 0, 1, 32'h7,        0));
    tbl.push_back(mk(1, 32'h0,        1, 0, 1, 32'h5,        2,   0, 1, 0, 1, 32'h7,        0));
    tbl.push_back(mk(1, 32'h0,        0, 1, 1, 32'h5,        2,   0, 1, 0, 1, 32'h7,        0));
    tbl.push_back(mk(1, 32'h0,        0, 0, 1, 32'h5,        2,   1, 0, 0, 0, 32'h0,        0));
    // undecoded offset, then high address bits ignored on RX_POPPED
    tbl.push_back(mk(1, 32'h10,       1, 1, 1, 32'h5,        0,   1, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 32'h0,        0, 1, 1, 32'h5,        0,   0, 1, 0, 1, 32'h0,        3));
    tbl.push_back(mk(1, 32'h12345608, 1, 1, 1, 32'h5,        0,   1, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 32'h0,        0, 1, 1, 32'h5,        0,   0, 1, 0, 1, 32'h1,        0));
    // arvalid held with rready high: one accept every other cycle
    tbl.push_back(mk(1, 32'h0,        1, 1, 1, 32'h11111111, 0,   1, 0, 1, 0, 32'h0,        0));
    tbl.push_back(mk(1, 32'h0,        1, 1, 1, 32'h22222222, 0,   0, 1, 0, 1, 32'h11111111, 0));
    tbl.push_back(mk(1, 32'h0,        1, 1, 1, 32'h33333333, 0,   1, 0, 1, 0, 32'h0,        0));
    tbl.push_back(mk(1, 32'h0,        0, 1, 1, 32'h44444444, 0,   0, 1, 0, 1, 32'h33333333, 0));
    tbl.push_back(mk(1, 32'h8,        1, 1, 0, 32'h0,        0,   1, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 32'h0,        0, 1, 0, 32'h0,        0,   0, 1, 0, 1, 32'h3,        0));
    // reset while a response is pending
    tbl.push_back(mk(1, 32'h0,        1, 0, 1, 32'hAAAA5555, 0,   1, 0, 1, 0, 32'h0,        0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 1, 32'hAAAA5555, 0,   0, 0, 0, 1, 32'hAAAA5555, 0));
    tbl.push_back(mk(1, 32'h0,        0, 0, 1, 32'h0,        0,   1, 0, 0, 1, 32'h0,        0));
    tbl.push_back(mk(1, 32'h8,        1, 1, 0, 32'h0,        0,   1, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 32'h0,        0, 1, 0, 32'h0,        0,   0, 1, 0, 1, 32'h0,        0));
    tbl.push_back(mk(1, 32'h0,        0, 0, 0, 32'h0,        0,   1, 0, 0, 0, 32'h0,        0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].addr, tbl[i].av, tbl[i].rr, tbl[i].rv, tbl[i].rq, tbl[i].cnt);
      chk($sformatf("vec%0d arready", i), {31'd0, arready},     {31'd0, tbl[i].e_ar});
      chk($sformatf("vec%0d rvalid", i),  {31'd0, rvalid},      {31'd0, tbl[i].e_rv});
      chk($sformatf("vec%0d yumi", i),    {31'd0, rx_req_yumi}, {31'd0, tbl[i].e_y});
      if (tbl[i].chk_d) begin
        chk($sformatf("vec%0d rdata", i), rdata,              tbl[i].e_rd);
        chk($sformatf("vec%0d rresp", i), {30'd0, rresp},     {30'd0, tbl[i].e_rs});
      end
      model_eval();
      model_adv();
    end

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 4))
        0: a = {$urandom_range(0, 32'hFFFFFF), 8'h00};
        1: a = {$urandom_range(0, 32'hFFFFFF), 8'h04};
        2: a = {$urandom_range(0, 32'hFFFFFF), 8'h08};
        3: a = $urandom;
        default: a = 32'h0;
      endcase
      drive(($urandom_range(0, 63) != 0), a, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0), $urandom_range(0, 1), $urandom,
            5'($urandom_range(0, 31)));
      model_eval();
      chk("rand arready", {31'd0, arready},     {31'd0, m_ar});
      chk("rand rvalid",  {31'd0, rvalid},      {31'd0, m_rv});
      chk("rand yumi",    {31'd0, rx_req_yumi}, {31'd0, m_y});
      chk("rand rdata",   rdata,                m_rd);
      chk("rand rresp",   {30'd0, rresp},       {30'd0, m_rs});
      model_adv();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
